// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) types and helpers for the receive decoder and transmit encoder.
// Bit cw[i-1] carries Hamming position i.
package ham_pkg;

  localparam int HAM_CW_W   = 7;
  localparam int HAM_WORD_W = 14;

  typedef logic [HAM_CW_W-1:0] ham_cw_t;
  typedef logic [2:0]          ham_syn_t;

  typedef struct packed {
    ham_cw_t  hi;
    ham_cw_t  lo;
    ham_syn_t syn_hi;
    ham_syn_t syn_lo;
  } ham_s1_t;

  function automatic ham_syn_t ham_syndrome(input ham_cw_t cw);
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

  function automatic logic [3:0] ham_extract(input ham_cw_t cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

endpackage

// File: rtl/ham74_correct.sv
// Single-error corrector for one Hamming(7,4) codeword.
// Flips the position named by a non-zero syndrome, then extracts the nibble.
module ham74_correct
  import ham_pkg::*;
(
  input  ham_cw_t    cw,
  input  ham_syn_t   syn,
  output logic [3:0] nibble,
  output logic       fixed
);

  ham_cw_t mask;

  always_comb begin
    fixed = |syn;
    mask  = '0;
    if (fixed)
      mask = ham_cw_t'(1) << (syn - 3'd1);
    nibble = ham_extract(cw ^ mask);
  end

endmodule

// File: rtl/ham_decode_14to8.sv
// Two-stage 14-to-8 Hamming decoder with valid/ready output and overrun flag.
// Optional saturating error counters are enabled by defining HAM_ERRCNT_EN.
module ham_decode_14to8
  import ham_pkg::*;
`ifdef HAM_ERRCNT_EN
#(
  parameter int ERRCNT_W = 16
)
`endif
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [HAM_WORD_W-1:0] hamcode,
  input  logic                  hamcode_valid,
  output logic                  in_ready,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [1:0]            corrected,
`ifdef HAM_ERRCNT_EN
  output logic [ERRCNT_W-1:0]   err_corr_cnt,
  output logic [ERRCNT_W-1:0]   err_overrun_cnt,
`endif
  output logic                  overrun
);

  ham_s1_t    s1;
  logic       s1_full;
  logic       s1_load;
  logic       s2_load;
  logic       drop;
  logic [3:0] nib_hi;
  logic [3:0] nib_lo;
  logic       fix_hi;
  logic       fix_lo;

  assign s2_load  = s1_full && (!data_valid || data_ready);
  assign in_ready = !s1_full || s2_load;
  assign s1_load  = hamcode_valid && in_ready;
  assign drop     = hamcode_valid && !in_ready;

  ham74_correct u_corr_hi (
    .cw     (s1.hi),
    .syn    (s1.syn_hi),
    .nibble (nib_hi),
    .fixed  (fix_hi)
  );

  ham74_correct u_corr_lo (
    .cw     (s1.lo),
    .syn    (s1.syn_lo),
    .nibble (nib_lo),
    .fixed  (fix_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s1_full <= 1'b0;
    end else if (s1_load) begin
      s1.hi     <= hamcode[13:7];
      s1.lo     <= hamcode[6:0];
      s1.syn_hi <= ham_syndrome(hamcode[13:7]);
      s1.syn_lo <= ham_syndrome(hamcode[6:0]);
      s1_full   <= 1'b1;
    end else if (s2_load) begin
      s1_full <= 1'b0;
    end
  end

  // S2 holds its word until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      corrected  <= '0;
      data_valid <= 1'b0;
    end else if (s2_load) begin
      data_out   <= {nib_hi, nib_lo};
      corrected  <= {fix_hi, fix_lo};
      data_valid <= 1'b1;
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
  end

`ifdef HAM_ERRCNT_EN
  logic [1:0]        n_fix;
  logic [ERRCNT_W:0] corr_sum;
  logic [ERRCNT_W:0] ovr_sum;

  assign n_fix    = {1'b0, fix_hi} + {1'b0, fix_lo};
  assign corr_sum = {1'b0, err_corr_cnt} + (ERRCNT_W+1)'(n_fix);
  assign ovr_sum  = {1'b0, err_overrun_cnt} + (ERRCNT_W+1)'(drop);

  // carry out of the sum means the counter would wrap, so pin it at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_corr_cnt    <= '0;
      err_overrun_cnt <= '0;
    end else begin
      if (s2_load)
        err_corr_cnt <= corr_sum[ERRCNT_W] ? '1 : corr_sum[ERRCNT_W-1:0];
      if (drop)
        err_overrun_cnt <= ovr_sum[ERRCNT_W] ? '1 : ovr_sum[ERRCNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_ham_decode_14to8.sv
// Scoreboard bench for ham_decode_14to8 using hand-computed codewords.
// Counter checks are compiled in when HAM_ERRCNT_EN is defined.
module tb_ham_decode_14to8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] hamcode = '0;
  logic        hamcode_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic [1:0]  corrected;
  logic        overrun;
`ifdef HAM_ERRCNT_EN
  logic [15:0] err_corr_cnt;
  logic [15:0] err_overrun_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [9:0] sb_q [$];

  // valid codewords for nibbles 0..F, layout {d4,d3,d2,p4,d1,p2,p1}
  logic [6:0] cw_tab [16] = '{
    7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
    7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F
  };

  always #5 clk = ~clk;

  ham_decode_14to8 dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .hamcode         (hamcode),
    .hamcode_valid   (hamcode_valid),
    .in_ready        (in_ready),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .corrected       (corrected),
`ifdef HAM_ERRCNT_EN
    .err_corr_cnt    (err_corr_cnt),
    .err_overrun_cnt (err_overrun_cnt),
`endif
    .overrun         (overrun)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [13:0] w, input bit push,
                        input logic [7:0] d, input logic [1:0] c);
    hamcode       = w;
    hamcode_valid = 1'b1;
    if (push)
      sb_q.push_back({d, c});
    step();
    hamcode_valid = 1'b0;
  endtask

  // monitor: a transfer happens at the next edge when valid && ready now
  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %0h expected none", data_out);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        if ({data_out, corrected} !== e) begin
          fails++;
          $display("FAIL output: got data %0h corr %0b expected data %0h corr %0b",
                   data_out, corrected, e[9:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_corrected", corrected, 0);
    check("rst_overrun", overrun, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef HAM_ERRCNT_EN
    check("rst_corr_cnt", err_corr_cnt, 0);
    check("rst_ovr_cnt", err_overrun_cnt, 0);
`endif
    reset_n = 1'b1;
    step();

    // clean word and latency
    strobe(14'h292D, 1, 8'hA5, 2'b00);
    check("lat_n1_valid", data_valid, 0);
    step();
    check("lat_n2_valid", data_valid, 1);
    repeat (2) step();

    strobe(14'h2925, 1, 8'hA5, 2'b01);
    repeat (3) step();
`ifdef HAM_ERRCNT_EN
    check("corr_cnt_single", err_corr_cnt, 1);
`endif

    strobe(14'h292D ^ 14'h0081, 1, 8'hA5, 2'b11);
    repeat (3) step();
`ifdef HAM_ERRCNT_EN
    check("corr_cnt_double", err_corr_cnt, 3);
`endif

    // backpressure and overrun
    data_ready = 1'b0;
    strobe(14'h0000, 1, 8'h00, 2'b00);
    strobe(14'h292D, 1, 8'hA5, 2'b00);
    check("bp_in_ready_full", in_ready, 0);
    strobe(14'h0000, 0, 8'h00, 2'b00);
    check("bp_overrun", overrun, 1);
    check("bp_valid", data_valid, 1);
    check("bp_data_held", data_out, 8'h00);
    repeat (3) step();
    check("bp_data_stable", data_out, 8'h00);
    check("bp_overrun_sticky", overrun, 1);
`ifdef HAM_ERRCNT_EN
    check("ovr_cnt", err_overrun_cnt, 1);
`endif
    data_ready = 1'b1;
    repeat (4) step();
    check("bp_drained_valid", data_valid, 0);
    check("bp_drained_queue", sb_q.size(), 0);
    check("bp_overrun_after", overrun, 1);

    // reset mid-flight with both stages occupied
    data_ready = 1'b0;
    strobe(14'h0000, 0, 8'h00, 2'b00);
    strobe(14'h292D, 0, 8'h00, 2'b00);
    step();
    check("pre_rst_valid", data_valid, 1);
    check("pre_rst_in_ready", in_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_overrun", overrun, 0);
    step();
    reset_n    = 1'b1;
    data_ready = 1'b1;
    step();
    strobe(14'h292D, 1, 8'hA5, 2'b00);
    repeat (3) step();
    check("post_rst_queue", sb_q.size(), 0);

    // streaming 16 words; odd words carry one low-nibble bit error
    for (int i = 0; i < 16; i++) begin
      logic [6:0] lo;
      lo = cw_tab[15-i];
      if (i % 2 == 1)
        lo = lo ^ (7'd1 << (i % 7));
      check("stream_in_ready", in_ready, 1);
      strobe({cw_tab[i], lo}, 1, {4'(i), 4'(15 - i)},
             (i % 2 == 1) ? 2'b01 : 2'b00);
      if (i >= 1)
        check("stream_valid", data_valid, 1);
    end
    step();
    check("stream_valid_17", data_valid, 1);
    step();
    check("stream_valid_18", data_valid, 0);
    check("stream_overrun", overrun, 0);
    repeat (3) step();
    check("final_queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
